adder_tree_pipe: RTL and testbench
==================================

Name: adder_tree_pipe

Overview:
- Parametrised, fully pipelined N-input adder tree with a valid/ready stream interface. Replaces the fixed 8-input, single-register tree.
- Adds arbitrary power-of-two fan-in, signed/unsigned mode and a register after every level.
- Adds global backpressure and an optional multi-beat accumulate mode with sticky overflow.
- Sits between operand producers (e.g. MAC arrays) and downstream consumers of reduced sums.

Parameters:
- WIDTH, 48, bits per input operand.
- NUM_IN, 8, number of operands; power of two, ≥2.
- LEVELS, $clog2(NUM_IN), derived; not overridable.
- SIGNED, 0; 1 = two's-complement operands, sign-extended at each level.
- ACC_BITS, 8, extra accumulator headroom bits.
- OW, WIDTH+LEVELS+ACC_BITS, derived output width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  NUM_IN*WIDTH  operands; operand i = in_data[i*WIDTH +: WIDTH].
- in_acc  in  1  beat belongs to an accumulate packet.
- in_last  in  1  final beat of an accumulate packet; ignored when in_acc=0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  OW  result, zero-/sign-extended per SIGNED.
- out_ovf  out  1  accumulate packet overflowed OW; 0 for non-acc results.

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset: all stage valids 0, accumulator 0, packet-open flag 0, out_valid 0, out_sum 0, out_ovf 0. in_ready is 0 while rst_n=0.
- Global enable en = !out_valid || out_ready. in_ready = en (when rst_n=1). A beat is accepted on an edge where in_valid && in_ready.
- Stall: when en=0, every pipeline register, including side-band and the output register, holds. No beat is lost or duplicated. Bubbles are not collapsed.
- Pipeline:
  - The accepting edge captures operands into stage 0.
  - Level k (1..LEVELS) registers pairwise sums at the next LEVELS edges. Level k width is WIDTH+k.
  - The output/accumulator register updates on the following edge.
  - Latency with no stall: out_valid rises LEVELS+1 edges after the accepting edge (4 for NUM_IN=8). Throughput is 1 beat/cycle.
- Side-band (valid, acc, last) travels with data through every stage.
- Output stage, for a tree result T (extended to OW):
  - acc=0: out_sum=T, out_ovf=0. The accumulator and packet state are untouched, even if a packet is open.
  - acc=1, last=0: accumulator += T; the ovf sticky bit ORs in overflow of this add; no output.
  - acc=1, last=1: out_sum = accumulator+T; out_ovf = sticky | this-add overflow. Accumulator and sticky clear to 0 on the same edge.
  - Overflow definition: unsigned = carry out of OW bits; signed = operands of equal sign produce a result of opposite sign. The value wraps modulo 2^OW.
- out_sum and out_ovf are stable while out_valid && !out_ready.
- A single-beat packet (acc=1, last=1) outputs T.
- Reset mid-operation drops all in-flight beats and any partial accumulation. The first post-reset packet starts from 0.

Decomposition:
- Package adder_tree_pkg holds:
  - out-width and level-width functions;
  - a stream side-band struct typedef {valid, acc, last}.
- Sub-module adder_tree_level holds one registered reduction level.
  - Parameters: PAIRS, IN_W, SIGNED.
  - Ports: clk, rst_n, en, sideband in/out, data in/out.
  - It is instantiated LEVELS times via generate.
  - The top holds the input stage, output/accumulator stage and handshake.

Test Plan (NUM_IN=8, WIDTH=48 unless noted):
1. All operands 48'hFFFF_FFFF_FFFF, SIGNED=0, in_acc=0 -> out_sum=0x7_FFFF_FFFF_FFF8 (8·(2^48−1)), 4 edges after accept, out_ovf=0.
2. SIGNED=1, all operands −1 -> out_sum = −8 sign-extended over OW=59 bits; operands {+5, −3, 0…} -> +2.
3. 10 back-to-back beats with operand i = beat+i, out_ready=1 -> 10 consecutive out_valid cycles with correct sums in order; in_ready constantly 1.
4. Same stream with out_ready low for 3 cycles mid-stream -> in_ready low for exactly those cycles; out_sum held stable; all 10 results delivered once, in order.
5. Accumulate: 3 beats of all-ones operands (T=8), last on beat 3 -> single output 24, out_ovf=0. Then ACC_BITS=1 (OW=52), 4 beats of all-max operands with last on beat 4 -> out_sum=0xF_FFFF_FFFF_FFE0, out_ovf=1.
6. Open a packet with 2 acc beats, drive rst_n=0 for 1 cycle, then send 1 beat (T=8, acc=1, last=1) -> output 8, no residue, out_ovf=0.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared types and width helpers for the pipelined adder tree.
package adder_tree_pkg;

  // Side-band carried alongside the data through every pipeline stage.
  typedef struct packed {
    logic valid;
    logic acc;
    logic last;
  } sb_t;

  // Width of the partial sums registered at tree level k (level 0 = raw operands).
  function automatic int unsigned level_width(int unsigned width, int unsigned k);
    return width + k;
  endfunction

  // Output / accumulator width: full tree growth plus accumulate headroom.
  function automatic int unsigned out_width(int unsigned width, int unsigned num_in,
                                            int unsigned acc_bits);
    return width + $clog2(num_in) + acc_bits;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: PAIRS adjacent operand pairs summed with one bit of growth.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int unsigned PAIRS  = 4,
  parameter int unsigned IN_W   = 48,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  sb_t                         sb_i,
  output sb_t                         sb_o,
  input  logic [2*PAIRS*IN_W-1:0]     data_i,
  output logic [PAIRS*(IN_W+1)-1:0]   data_o
);

  localparam int unsigned OutW = IN_W + 1;

  logic [PAIRS*OutW-1:0] sum_d, sum_q;
  sb_t                   sb_q;

  // Extend one operand by a bit so the pair sum cannot wrap.
  function automatic logic [OutW-1:0] ext(logic [IN_W-1:0] x);
    return {(SIGNED ? x[IN_W-1] : 1'b0), x};
  endfunction

  // Pairwise sums of operand 2p and 2p+1.
  always_comb begin
    sum_d = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      sum_d[p*OutW +: OutW] = ext(data_i[2*p*IN_W +: IN_W]) + ext(data_i[(2*p+1)*IN_W +: IN_W]);
    end
  end

  // Level register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      sb_q  <= '0;
    end else if (en) begin
      sum_q <= sum_d;
      sb_q  <= sb_i;
    end
  end

  assign data_o = sum_q;
  assign sb_o   = sb_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined NUM_IN-input adder tree with global backpressure and multi-beat accumulate.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH    = 48,
  parameter int unsigned NUM_IN   = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter int unsigned ACC_BITS = 8,
  localparam int unsigned LEVELS  = $clog2(NUM_IN),
  localparam int unsigned OW      = out_width(WIDTH, NUM_IN, ACC_BITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_acc,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           out_sum,
  output logic                    out_ovf
);

  localparam int unsigned TW = level_width(WIDTH, LEVELS);

  logic                    en;
  logic [NUM_IN*WIDTH-1:0] data0_q;
  sb_t                     sb0_q;

  logic [OW-1:0] acc_d, acc_q, out_sum_d, out_sum_q, t_ext, add_sum;
  logic          sticky_d, sticky_q, out_ovf_d, out_ovf_q, out_valid_d, out_valid_q;
  logic          carry, add_ovf;
  logic [TW-1:0] tree;
  sb_t           tree_sb;

  // One enable for the whole pipe: advance whenever the output slot is free or draining.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = rst_n && en;

  // Input stage: capture operands and side-band; a bubble is recorded when in_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data0_q <= '0;
      sb0_q   <= '0;
    end else if (en) begin
      data0_q <= in_data;
      sb0_q   <= '{valid: in_valid, acc: in_acc, last: in_last};
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned InW   = WIDTH + k - 1;
    localparam int unsigned Pairs = NUM_IN >> k;

    logic [2*Pairs*InW-1:0]   d_in;
    logic [Pairs*(InW+1)-1:0] d_out;
    sb_t                      sb_in, sb_out;

    if (k == 1) begin : g_first
      assign d_in  = data0_q;
      assign sb_in = sb0_q;
    end else begin : g_next
      assign d_in  = g_lvl[k-1].d_out;
      assign sb_in = g_lvl[k-1].sb_out;
    end

    adder_tree_level #(
      .PAIRS  (Pairs),
      .IN_W   (InW),
      .SIGNED (SIGNED)
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sb_i   (sb_in),
      .sb_o   (sb_out),
      .data_i (d_in),
      .data_o (d_out)
    );
  end

  assign tree    = g_lvl[LEVELS].d_out;
  assign tree_sb = g_lvl[LEVELS].sb_out;

  // Extend the tree result to OW and form accumulator + result with overflow detection.
  always_comb begin
    t_ext          = '0;
    t_ext[TW-1:0]  = tree;
    for (int unsigned i = TW; i < OW; i++) begin
      t_ext[i] = SIGNED & tree[TW-1];
    end
    {carry, add_sum} = {1'b0, acc_q} + {1'b0, t_ext};
    if (SIGNED) begin
      add_ovf = (acc_q[OW-1] == t_ext[OW-1]) && (add_sum[OW-1] != acc_q[OW-1]);
    end else begin
      add_ovf = carry;
    end
  end

  // Output / accumulator next state; plain results bypass the accumulator entirely.
  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (en) begin
      out_valid_d = tree_sb.valid && (!tree_sb.acc || tree_sb.last);
      if (tree_sb.valid) begin
        if (!tree_sb.acc) begin
          out_sum_d = t_ext;
          out_ovf_d = 1'b0;
        end else if (!tree_sb.last) begin
          acc_d    = add_sum;
          sticky_d = sticky_q | add_ovf;
        end else begin
          out_sum_d = add_sum;
          out_ovf_d = sticky_q | add_ovf;
          acc_d     = '0;
          sticky_d  = 1'b0;
        end
      end
    end
  end

  // Output / accumulator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench: three configurations (unsigned, signed, ACC_BITS=1) driven with one shared stream
// and each checked against an arithmetic reference model.
module tb_adder_tree_pipe;

  typedef struct packed {
    logic [63:0] s;
    logic        o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_acc, in_last, out_ready;
  logic [383:0] in_data;
  logic [2:0]   in_rdy, o_valid, o_ovf;
  logic [58:0]  s0, s1;
  logic [51:0]  s2;
  logic [63:0]  got_sum [3];

  int           total = 0;
  int           bad   = 0;
  exp_t         q [3][$];
  longint       acc_m [3];
  logic         sticky_m [3];
  logic [63:0]  last_s [3];
  logic         last_o [3];
  logic         rdy_seen, ov_seen;

  always #5 clk = ~clk;

  assign got_sum[0] = {5'b0, s0};
  assign got_sum[1] = {5'b0, s1};
  assign got_sum[2] = {12'b0, s2};

  adder_tree_pipe u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .in_acc(in_acc), .in_last(in_last), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_sum(s0), .out_ovf(o_ovf[0])
  );

  adder_tree_pipe #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .in_acc(in_acc), .in_last(in_last), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_sum(s1), .out_ovf(o_ovf[1])
  );

  adder_tree_pipe #(.ACC_BITS(1)) u_acc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_data(in_data),
    .in_acc(in_acc), .in_last(in_last), .out_valid(o_valid[2]), .out_ready(out_ready),
    .out_sum(s2), .out_ovf(o_ovf[2])
  );

  function automatic bit cfg_sgn(int d);
    return d == 1;
  endfunction

  function automatic int cfg_ow(int d);
    return (d == 2) ? 52 : 59;
  endfunction

  function automatic longint opv(logic [47:0] x, bit sg);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint tree_sum(logic [383:0] d, bit sg);
    longint t = 0;
    for (int i = 0; i < 8; i++) t += opv(d[i*48 +: 48], sg);
    return t;
  endfunction

  // Reduce to the OW-bit range: [0,2^OW) unsigned, [-2^(OW-1),2^(OW-1)) signed.
  function automatic longint wrapv(longint v, int ow, bit sg);
    longint m = longint'(1) <<< ow;
    longint r = v % m;
    if (r < 0) r += m;
    if (sg && r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic logic [63:0] pat(longint v, int ow);
    longint m = longint'(1) <<< ow;
    return 64'(v & (m - 1));
  endfunction

  function automatic logic [383:0] mk_lin(int base);
    logic [383:0] r;
    for (int i = 0; i < 8; i++) r[i*48 +: 48] = 48'(base + i);
    return r;
  endfunction

  function automatic logic [383:0] mk_fill(logic [47:0] v);
    logic [383:0] r;
    for (int i = 0; i < 8; i++) r[i*48 +: 48] = v;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(logic [383:0] d, logic a, logic l);
    for (int i = 0; i < 3; i++) begin
      bit     sg = cfg_sgn(i);
      int     ow = cfg_ow(i);
      longint m  = longint'(1) <<< ow;
      longint t  = tree_sum(d, sg);
      longint s;
      bit     o;
      if (!a) begin
        q[i].push_back('{s: pat(t, ow), o: 1'b0});
      end else begin
        s = acc_m[i] + t;
        o = sg ? (s >= m / 2 || s < -(m / 2)) : (s >= m);
        acc_m[i]    = wrapv(s, ow, sg);
        sticky_m[i] = sticky_m[i] | o;
        if (l) begin
          q[i].push_back('{s: pat(acc_m[i], ow), o: sticky_m[i]});
          acc_m[i]    = 0;
          sticky_m[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      acc_m[i]    = 0;
      sticky_m[i] = 1'b0;
      last_s[i]   = '0;
      last_o[i]   = 1'b0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs, update model, advance.
  task automatic cycle(logic v, logic a, logic l, logic [383:0] d, logic rdy, output bit ok);
    in_valid = v; in_acc = a; in_last = l; in_data = d; out_ready = rdy;
    #1;
    rdy_seen = in_rdy[0];
    ov_seen  = o_valid[0];
    for (int i = 0; i < 3; i++) begin
      if (o_valid[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("spurious_out%0d", i), 64'(o_valid[i]), 64'd0);
        end else begin
          chk($sformatf("sum%0d", i), got_sum[i], q[i][0].s);
          chk($sformatf("ovf%0d", i), 64'(o_ovf[i]), 64'(q[i][0].o));
          if (rdy) begin
            last_s[i] = q[i][0].s;
            last_o[i] = q[i][0].o;
            void'(q[i].pop_front());
          end
        end
      end
    end
    ok = v && in_rdy[0];
    if (ok) model_accept(d, a, l);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    bit ok;
    repeat (n) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           ok;
    int           nb;
    logic [383:0] d;

    rst_n = 1'b0; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 64'(in_rdy[i]), 64'd0);
      chk($sformatf("rst_out_valid%0d", i), 64'(o_valid[i]), 64'd0);
      chk($sformatf("rst_out_sum%0d", i), got_sum[i], 64'd0);
      chk($sformatf("rst_out_ovf%0d", i), 64'(o_ovf[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Max operands, plain beat: latency and full-scale sums.
    cycle(1'b1, 1'b0, 1'b0, mk_fill(48'hFFFF_FFFF_FFFF), 1'b1, ok);
    chk("t1_accept", 64'(ok), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("t1_lat%0d", i), 64'(o_valid[0]), 64'(i == 5));
      if (i == 5) begin
        chk("t1_sum_uns", got_sum[0], 64'h0007_FFFF_FFFF_FFF8);
        chk("t2_sum_neg8", got_sum[1], 64'h07FF_FFFF_FFFF_FFF8);
      end
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, ok);
    end
    idle(2);

    // Mixed-sign operands.
    d = '0;
    d[47:0]  = 48'd5;
    d[95:48] = 48'hFFFF_FFFF_FFFD;
    cycle(1'b1, 1'b0, 1'b0, d, 1'b1, ok);
    idle(6);
    chk("t2_sum_pos2", last_s[1], 64'd2);

    // Ten back-to-back beats, no backpressure.
    for (int b = 0; b < 10; b++) begin
      cycle(1'b1, 1'b0, 1'b0, mk_lin(b), 1'b1, ok);
      chk("t3_in_ready", 64'(rdy_seen), 64'd1);
      chk("t3_out_valid", 64'(ov_seen), 64'(b >= 5));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, ok);
      chk("t3_drain_valid", 64'(ov_seen), 64'(i < 5));
    end

    // Same stream with a three-cycle consumer stall mid-stream.
    nb = 0;
    for (int c = 0; c < 40 && nb < 10; c++) begin
      logic rdy;
      rdy = !(c >= 6 && c <= 8);
      cycle(1'b1, 1'b0, 1'b0, mk_lin(nb), rdy, ok);
      chk("t4_in_ready", 64'(rdy_seen), 64'(rdy));
      if (ok) nb++;
    end
    chk("t4_beats", 64'(nb), 64'd10);
    idle(10);
    for (int i = 0; i < 3; i++) chk("t4_drained", 64'(q[i].size()), 64'd0);

    // Accumulate packets: small values, then overflow of the narrow accumulator.
    for (int b = 0; b < 3; b++) cycle(1'b1, 1'b1, 1'(b == 2), mk_fill(48'd1), 1'b1, ok);
    idle(7);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_acc24_%0d", i), last_s[i], 64'd24);
      chk($sformatf("t5_ovf0_%0d", i), 64'(last_o[i]), 64'd0);
    end
    for (int b = 0; b < 4; b++) begin
      cycle(1'b1, 1'b1, 1'(b == 3), mk_fill(48'hFFFF_FFFF_FFFF), 1'b1, ok);
    end
    idle(7);
    chk("t5_wrap_sum", last_s[2], 64'h000F_FFFF_FFFF_FFE0);
    chk("t5_wrap_ovf", 64'(last_o[2]), 64'd1);

    // Reset with a packet open must discard the partial sum.
    cycle(1'b1, 1'b1, 1'b0, mk_fill(48'd1), 1'b1, ok);
    cycle(1'b1, 1'b1, 1'b0, mk_fill(48'd1), 1'b1, ok);
    idle(6);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(in_rdy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 1'b1, mk_fill(48'd1), 1'b1, ok);
    idle(6);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_sum%0d", i), last_s[i], 64'd8);
      chk($sformatf("t6_ovf%0d", i), 64'(last_o[i]), 64'd0);
    end

    // Random mix of plain and accumulate beats with random backpressure.
    for (int c = 0; c < 300; c++) begin
      logic v, a, l, rdy;
      v   = ($urandom_range(0, 3) != 0);
      a   = 1'($urandom_range(0, 1));
      l   = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        d = mk_fill(48'hFFFF_FFFF_FFFF);
      end else begin
        for (int i = 0; i < 8; i++) d[i*48 +: 48] = 48'({$urandom(), $urandom()});
      end
      cycle(v, a, l, d, rdy, ok);
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) cycle(1'b1, 1'b1, 1'b1, mk_lin(c), 1'b1, ok);
    chk("t7_close_accept", 64'(ok), 64'd1);
    idle(12);
    for (int i = 0; i < 3; i++) chk($sformatf("t7_drained%0d", i), 64'(q[i].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
